// File: rtl/ex_stage_skid_reg.sv
// ex_stage_skid_reg
//   ID->EX pipeline boundary register with a two-entry skid buffer (main + skid),
//   valid/ready handshakes on both sides, synchronous flush for branch/exception
//   squash, and a saturating counter of back-pressure cycles.
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     flush           squash every held entry on this edge
//     id_valid/ready  upstream handshake (id_ready is registered)
//     id_*            decoded instruction payload from decode
//     ex_valid/ready  downstream handshake
//     ex_*            registered payload to execute (NOP values when empty)
//     stall_cnt       saturating count of cycles with ex_valid & !ex_ready
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_EMPTY | main invalid, skid invalid; id_ready=1
//   S_ONE   | main valid, skid invalid; id_ready=1
//   S_FULL  | main valid, skid valid; id_ready=0, no accept possible
module ex_stage_skid_reg #(
   parameter int ALUOP_W    = 8,
   parameter int ALUSEL_W   = 3,
   parameter int DATA_W     = 32,
   parameter int RADDR_W    = 5,
   parameter int CNT_W      = 16,
   parameter int NOP_ALUOP  = 0,
   parameter int NOP_ALUSEL = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                id_valid,
   output logic                id_ready,
   input  logic [ALUOP_W-1:0]  id_aluop,
   input  logic [ALUSEL_W-1:0] id_alusel,
   input  logic [DATA_W-1:0]   id_reg1,
   input  logic [DATA_W-1:0]   id_reg2,
   input  logic                id_wreg,
   input  logic [RADDR_W-1:0]  id_wd,
   output logic                ex_valid,
   input  logic                ex_ready,
   output logic [ALUOP_W-1:0]  ex_aluop,
   output logic [ALUSEL_W-1:0] ex_alusel,
   output logic [DATA_W-1:0]   ex_reg1,
   output logic [DATA_W-1:0]   ex_reg2,
   output logic                ex_wreg,
   output logic [RADDR_W-1:0]  ex_wd,
   output logic [CNT_W-1:0]    stall_cnt
);

   typedef struct packed {
      logic [ALUOP_W-1:0]  aluop;
      logic [ALUSEL_W-1:0] alusel;
      logic [DATA_W-1:0]   reg1;
      logic [DATA_W-1:0]   reg2;
      logic                wreg;
      logic [RADDR_W-1:0]  wd;
   } entry_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   localparam entry_t NOP_ENTRY = '{
      aluop:  ALUOP_W'(NOP_ALUOP),
      alusel: ALUSEL_W'(NOP_ALUSEL),
      reg1:   '0,
      reg2:   '0,
      wreg:   1'b0,
      wd:     '0
   };

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t state_q, state_d;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   entry_t id_entry;
   logic   accept;
   logic   fire;

   assign id_entry = '{
      aluop:  id_aluop,
      alusel: id_alusel,
      reg1:   id_reg1,
      reg2:   id_reg2,
      wreg:   id_wreg,
      wd:     id_wd
   };

   // id_ready depends only on the state register, never on ex_ready.
   assign id_ready = (state_q != S_FULL);
   assign ex_valid = (state_q != S_EMPTY);
   assign accept   = id_valid & id_ready;
   assign fire     = ex_valid & ex_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = S_EMPTY;
         main_d  = NOP_ENTRY;
         skid_d  = NOP_ENTRY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  state_d = S_ONE;
                  main_d  = id_entry;
               end
            end
            S_ONE: begin
               if (fire && accept) begin
                  main_d = id_entry;
               end else if (fire) begin
                  state_d = S_EMPTY;
                  main_d  = NOP_ENTRY;
               end else if (accept) begin
                  state_d = S_FULL;
                  skid_d  = id_entry;
               end
            end
            S_FULL: begin
               if (fire) begin
                  state_d = S_ONE;
                  main_d  = skid_q;
                  skid_d  = NOP_ENTRY;
               end
            end
            default: begin
               state_d = S_EMPTY;
               main_d  = NOP_ENTRY;
               skid_d  = NOP_ENTRY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_EMPTY;
         main_q  <= NOP_ENTRY;
         skid_q  <= NOP_ENTRY;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (ex_valid && !ex_ready && !flush && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign ex_aluop  = main_q.aluop;
   assign ex_alusel = main_q.alusel;
   assign ex_reg1   = main_q.reg1;
   assign ex_reg2   = main_q.reg2;
   assign ex_wreg   = main_q.wreg;
   assign ex_wd     = main_q.wd;

endmodule

// File: tb/tb_ex_stage_skid_reg.sv
module tb_ex_stage_skid_reg;

   localparam int CNT_W = 3;

   typedef struct packed {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic        wreg;
      logic [4:0]  wd;
   } pl_t;

   logic        clk = 1'b0;
   logic        rst, flush, id_valid, id_ready, ex_valid, ex_ready;
   logic [7:0]  id_aluop, ex_aluop;
   logic [2:0]  id_alusel, ex_alusel;
   logic [31:0] id_reg1, id_reg2, ex_reg1, ex_reg2;
   logic        id_wreg, ex_wreg;
   logic [4:0]  id_wd, ex_wd;
   logic [CNT_W-1:0] stall_cnt;

   int n_total = 0;
   int n_pass  = 0;

   // reference model: FIFO of held instructions (at most two) + counter
   pl_t m_q[$];
   int  m_cnt = 0;

   always #5 clk = ~clk;

   ex_stage_skid_reg #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_aluop(id_aluop), .id_alusel(id_alusel),
      .id_reg1(id_reg1), .id_reg2(id_reg2),
      .id_wreg(id_wreg), .id_wd(id_wd),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
      .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
      .ex_wreg(ex_wreg), .ex_wd(ex_wd),
      .stall_cnt(stall_cnt)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic pl_t dut_pl();
      return {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wreg, ex_wd};
   endfunction

   task automatic compare_model();
      pl_t exp_pl;
      exp_pl = (m_q.size() > 0) ? m_q[0] : '0;
      chk("ex_valid",  128'(ex_valid),  128'(m_q.size() > 0));
      chk("id_ready",  128'(id_ready),  128'(m_q.size() < 2));
      chk("payload",   128'(dut_pl()),  128'(exp_pl));
      chk("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
   endtask

   // apply inputs, advance one edge, update model from pre-edge state, compare
   task automatic step(input logic r, input logic f, input logic iv, input logic er, input pl_t p);
      bit do_fire, do_acc, stalled;
      rst = r; flush = f; id_valid = iv; ex_ready = er;
      {id_aluop, id_alusel, id_reg1, id_reg2, id_wreg, id_wd} = p;
      do_fire = (m_q.size() > 0) && er;
      do_acc  = iv && (m_q.size() < 2);
      stalled = (m_q.size() > 0) && !er;
      @(posedge clk);
      if (r) begin
         m_q.delete();
         m_cnt = 0;
      end else if (f) begin
         m_q.delete();
      end else begin
         if (stalled && m_cnt < (2**CNT_W - 1)) m_cnt++;
         if (do_fire) void'(m_q.pop_front());
         if (do_acc) m_q.push_back(p);
      end
      #1;
      compare_model();
   endtask

   function automatic pl_t mk(input logic [7:0] op, input logic [31:0] r1,
                              input logic wr, input logic [4:0] wd);
      pl_t p;
      p = '0;
      p.aluop = op; p.reg1 = r1; p.wreg = wr; p.wd = wd;
      p.reg2 = ~r1; p.alusel = 3'd5;
      return p;
   endfunction

   initial begin
      pl_t rp;
      rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
      {id_aluop, id_alusel, id_reg1, id_reg2, id_wreg, id_wd} = '0;

      // reset
      step(1, 0, 0, 0, '0);
      step(1, 0, 1, 1, mk(8'h55, 32'h9, 1, 5'd3));
      chk("rst_valid", 128'(ex_valid), 128'(0));
      chk("rst_ready", 128'(id_ready), 128'(1));
      chk("rst_cnt",   128'(stall_cnt), 128'(0));
      chk("rst_aluop", 128'(ex_aluop), 128'(0));

      // streaming at full throughput
      step(0, 0, 1, 1, mk(8'h21, 32'h0, 0, 5'd1));
      chk("stream_21", 128'(ex_aluop), 128'(8'h21));
      step(0, 0, 1, 1, mk(8'h22, 32'h0, 0, 5'd1));
      chk("stream_22", 128'(ex_aluop), 128'(8'h22));
      step(0, 0, 1, 1, mk(8'h23, 32'h0, 0, 5'd1));
      chk("stream_23", 128'(ex_aluop), 128'(8'h23));
      chk("stream_rdy", 128'({ex_valid, id_ready, stall_cnt}), 128'({1'b1, 1'b1, 3'd0}));
      step(0, 0, 0, 1, '0);
      chk("drain_valid", 128'(ex_valid), 128'(0));

      // back-pressure into skid
      step(0, 0, 1, 0, mk(8'h31, 32'h1, 0, 5'd2));
      step(0, 0, 1, 0, mk(8'h32, 32'h2, 0, 5'd2));
      chk("skid_ready", 128'(id_ready), 128'(0));
      chk("skid_reg1",  128'(ex_reg1),  128'(32'h1));
      step(0, 0, 0, 1, '0);
      chk("skid_fire_reg1",  128'(ex_reg1),  128'(32'h2));
      chk("skid_fire_ready", 128'(id_ready), 128'(1));
      step(0, 0, 0, 1, '0);

      // flush while full, with a coincident offer that must be squashed
      step(0, 0, 1, 0, mk(8'h41, 32'hA, 1, 5'd9));
      step(0, 0, 1, 0, mk(8'h42, 32'hB, 1, 5'd10));
      step(0, 1, 1, 1, mk(8'h43, 32'hC, 1, 5'd11));
      chk("flush_out", 128'({ex_valid, ex_wreg, ex_wd, ex_aluop, id_ready}),
          128'({1'b0, 1'b0, 5'd0, 8'd0, 1'b1}));
      chk("flush_cnt_kept", 128'(stall_cnt), 128'(2));
      step(0, 0, 0, 1, '0);
      chk("squash_gone", 128'(ex_valid), 128'(0));

      // stall counter saturation
      step(0, 0, 1, 0, mk(8'h51, 32'h5, 1, 5'd4));
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, '0);
      chk("sat_cnt", 128'(stall_cnt), 128'(7));
      step(0, 1, 0, 0, '0);
      chk("sat_after_flush", 128'(stall_cnt), 128'(7));

      // reset while full
      step(0, 0, 1, 0, mk(8'h61, 32'h6, 1, 5'd6));
      step(0, 0, 1, 0, mk(8'h62, 32'h7, 1, 5'd7));
      chk("full_wreg", 128'({ex_wreg, id_ready}), 128'({1'b1, 1'b0}));
      step(1, 0, 0, 0, '0);
      chk("midrst_out", 128'({ex_valid, ex_wreg, id_ready, stall_cnt}),
          128'({1'b0, 1'b0, 1'b1, 3'd0}));
      step(0, 0, 0, 1, '0);
      step(0, 0, 0, 1, '0);
      chk("midrst_gone", 128'(ex_valid), 128'(0));

      // fire and accept together in ONE
      step(0, 0, 1, 0, mk(8'h71, 32'h8, 1, 5'd3));
      step(0, 0, 1, 1, mk(8'h72, 32'h9, 1, 5'd7));
      chk("fa_wd",    128'(ex_wd),    128'(5'd7));
      chk("fa_ready", 128'(id_ready), 128'(1));

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rp = {$urandom(), $urandom(), $urandom()};
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), rp);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
